fifo_ctrl: RTL and testbench

Control block for the 8-entry x 32-bit FIFO register file. It owns the head/tail pointers and the occupancy count, and it runs the request state machine. It issues the write strobe and write address to the register bank, and the read address (to the 8-to-1 read mux) plus the output-register enable. Data never passes through this block. It only sequences the storage and the read-select path.

---
 rtl/fifo_ctrl.sv | 144 ++++++++++++++
 tb/tb_fifo_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: head/tail/occupancy and request FSM for the 8x32 FIFO register file; strobes one cycle after the sampling edge.
// No backpressure: rejected requests only pulse wr_err/rd_err. Define FIFO_CTRL_ALMOST_FLAGS_EN to add almost_full/almost_empty.
module fifo_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic          rd_en,
    output logic          we,
    output logic [AW-1:0] wAddr,
    output logic          re,
    output logic [AW-1:0] rAddr,
    output logic [AW:0]   data_count,
    output logic          full,
    output logic          empty,
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    output logic          almost_full,
    output logic          almost_empty,
`endif
    output logic          wr_ack,
    output logic          wr_err,
    output logic          rd_ack,
    output logic          rd_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        WR_ERR = 3'd2,
        READ   = 3'd3,
        RD_ERR = 3'd4,
        RDWR   = 3'd5
    } state_t;

    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_AFULL = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    state_t        state_q, state_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic          re_q, re_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic          wr_ack_q, wr_ack_d;
    logic          wr_err_q, wr_err_d;
    logic          rd_ack_q, rd_ack_d;
    logic          rd_err_q, rd_err_d;
    logic          do_wr, do_rd;

    // full/empty come straight from the registered count so they track it with no extra delay
    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    // State and all registered outputs; reset wins over any request in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            re_q     <= 1'b0;
            raddr_q  <= '0;
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            re_q     <= re_d;
            raddr_q  <= raddr_d;
            wr_ack_q <= wr_ack_d;
            wr_err_q <= wr_err_d;
            rd_ack_q <= rd_ack_d;
            rd_err_q <= rd_err_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        unique case ({wr_en, rd_en})
            2'b10:   state_d = full  ? WR_ERR : WRITE;
            2'b01:   state_d = empty ? RD_ERR : READ;
            2'b11:   state_d = RDWR;
            default: state_d = IDLE;
        endcase
    end

    // RDWR degrades to a single-sided transfer plus an error pulse at the full/empty boundaries
    always_comb begin
        do_wr    = (state_d == WRITE) || ((state_d == RDWR) && !full);
        do_rd    = (state_d == READ)  || ((state_d == RDWR) && !empty);
        wr_err_d = (state_d == WR_ERR) || ((state_d == RDWR) && full);
        rd_err_d = (state_d == RD_ERR) || ((state_d == RDWR) && empty);
        wr_ack_d = do_wr;
        rd_ack_d = do_rd;
        we_d     = do_wr;
        re_d     = do_rd;
        waddr_d  = do_wr ? tail_q : waddr_q;
        raddr_d  = do_rd ? head_q : raddr_q;
        tail_d   = do_wr ? (tail_q + PTR_ONE) : tail_q;
        head_d   = do_rd ? (head_q + PTR_ONE) : head_q;
        count_d  = count_q;
        unique case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    assign we         = we_q;
    assign wAddr      = waddr_q;
    assign re         = re_q;
    assign rAddr      = raddr_q;
    assign data_count = count_q;
    assign wr_ack     = wr_ack_q;
    assign wr_err     = wr_err_q;
    assign rd_ack     = rd_ack_q;
    assign rd_err     = rd_err_q;

`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    assign almost_full  = !reset && (count_q == CNT_AFULL);
    assign almost_empty = !reset && (count_q == CNT_ONE);
`endif

    a_wr_excl: assert property (@(posedge clk) disable iff (reset) !(wr_ack && wr_err));
    a_rd_excl: assert property (@(posedge clk) disable iff (reset) !(rd_ack && rd_err));
    a_cnt_max: assert property (@(posedge clk) disable iff (reset) count_q <= CNT_FULL);
    a_we_src:  assert property (@(posedge clk) disable iff (reset)
                                we_q |-> (state_q == WRITE || state_q == RDWR));

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: directed vector table then model-driven random traffic, both through a scoreboard queue.
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       we, re, full, empty, wr_ack, wr_err, rd_ack, rd_err;
    logic [2:0] wAddr, rAddr;
    logic [3:0] data_count;
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    logic       almost_full, almost_empty;
`endif

    fifo_ctrl #(.DEPTH(8), .AW(3)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en),
        .we(we), .wAddr(wAddr), .re(re), .rAddr(rAddr),
        .data_count(data_count), .full(full), .empty(empty),
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
        .almost_full(almost_full), .almost_empty(almost_empty),
`endif
        .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, wr, rd;
        logic       we;
        logic [2:0] wa;
        logic       re;
        logic [2:0] ra;
        logic [3:0] cnt;
        logic [3:0] flags;   // {wr_ack, wr_err, rd_ack, rd_err}
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // spec-level reference state for the random phase
    logic [2:0] m_head, m_tail, m_wa, m_ra;
    logic [3:0] m_cnt;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst, input logic wr, input logic rd, input logic e_we,
                       input int e_wa, input logic e_re, input int e_ra, input int e_cnt,
                       input logic [3:0] e_flags);
        vec_t v;
        v.rst = rst; v.wr = wr; v.rd = rd;
        v.we = e_we; v.wa = 3'(e_wa); v.re = e_re; v.ra = 3'(e_ra);
        v.cnt = 4'(e_cnt); v.flags = e_flags;
        vecs.push_back(v);
    endtask

    task automatic compare_one();
        vec_t e;
        if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e = exp_q.pop_front();
        check("we", int'(we), int'(e.we));
        check("re", int'(re), int'(e.re));
        if (e.we) check("wAddr", int'(wAddr), int'(e.wa));
        if (e.re) check("rAddr", int'(rAddr), int'(e.ra));
        check("data_count", int'(data_count), int'(e.cnt));
        check("full", int'(full), int'(e.cnt == 4'd8));
        check("empty", int'(empty), int'(e.cnt == 4'd0));
        check("wr_ack", int'(wr_ack), int'(e.flags[3]));
        check("wr_err", int'(wr_err), int'(e.flags[2]));
        check("rd_ack", int'(rd_ack), int'(e.flags[1]));
        check("rd_err", int'(rd_err), int'(e.flags[0]));
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
        check("almost_full", int'(almost_full), int'(e.cnt == 4'd7));
        check("almost_empty", int'(almost_empty), int'(e.cnt == 4'd1));
`endif
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        reset = v.rst; wr_en = v.wr; rd_en = v.rd;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        compare_one();
    endtask

    function automatic vec_t model_step(input logic rst, input logic wr, input logic rd);
        vec_t v;
        logic dw, dr;
        v.rst = rst; v.wr = wr; v.rd = rd;
        if (rst) begin
            m_head = '0; m_tail = '0; m_wa = '0; m_ra = '0; m_cnt = '0;
            v.we = 0; v.re = 0; v.wa = 0; v.ra = 0; v.cnt = 0; v.flags = 4'b0000;
            return v;
        end
        dw = wr && (m_cnt != 4'd8);
        dr = rd && (m_cnt != 4'd0);
        v.flags = {dw, wr && (m_cnt == 4'd8), dr, rd && (m_cnt == 4'd0)};
        if (dw) begin m_wa = m_tail; m_tail = m_tail + 3'd1; end
        if (dr) begin m_ra = m_head; m_head = m_head + 3'd1; end
        m_cnt = m_cnt + (dw ? 4'd1 : 4'd0) - (dr ? 4'd1 : 4'd0);
        v.we = dw; v.re = dr; v.wa = m_wa; v.ra = m_ra; v.cnt = m_cnt;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held two cycles with a write pending
        add(1,1,0, 0,0,0,0, 0, 4'b0000);
        add(1,1,0, 0,0,0,0, 0, 4'b0000);
        for (int i = 0; i < 8; i++) add(0,1,0, 1,i,0,0, i+1, 4'b1000);
        add(0,1,0, 0,7,0,0, 8, 4'b0100);
        for (int i = 0; i < 8; i++) add(0,0,1, 0,7,1,i, 7-i, 4'b0010);
        add(0,0,1, 0,7,0,7, 0, 4'b0001);
        add(0,0,0, 0,7,0,7, 0, 4'b0000);
        // wrap: write 5, read 5, write 6
        for (int i = 0; i < 5; i++) add(0,1,0, 1,i,0,7, i+1, 4'b1000);
        for (int i = 0; i < 5; i++) add(0,0,1, 0,4,1,i, 4-i, 4'b0010);
        for (int i = 0; i < 6; i++) add(0,1,0, 1,(5+i)%8,0,4, i+1, 4'b1000);
        // simultaneous at count 3
        for (int i = 0; i < 3; i++) add(0,0,1, 0,2,1,(5+i)%8, 5-i, 4'b0010);
        add(0,1,1, 1,3,1,0, 3, 4'b1010);
        // simultaneous at empty
        for (int i = 0; i < 3; i++) add(0,0,1, 0,3,1,1+i, 2-i, 4'b0010);
        add(0,1,1, 1,4,0,3, 1, 4'b1001);
        // simultaneous at full
        for (int i = 0; i < 7; i++) add(0,1,0, 1,(5+i)%8,0,3, 2+i, 4'b1000);
        add(0,1,1, 0,3,1,4, 7, 4'b0110);
        // reset the cycle after a write at count 4
        for (int i = 0; i < 3; i++) add(0,0,1, 0,3,1,5+i, 6-i, 4'b0010);
        add(0,1,0, 1,4,0,7, 5, 4'b1000);
        add(1,1,0, 0,0,0,0, 0, 4'b0000);
        add(0,1,0, 1,0,0,0, 1, 4'b1000);
        add(0,0,1, 0,0,1,0, 0, 4'b0010);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // random traffic against the reference model
        apply(model_step(1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 400; i++) begin
            logic r, w, d;
            r = ($urandom_range(0, 39) == 0);
            w = ($urandom_range(0, 99) < 55);
            d = ($urandom_range(0, 99) < 45);
            apply(model_step(r, w, d));
        end

        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
